// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: PRGA state encoding, printable-byte bounds, S-box depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rc4_pkg;

    // One byte of PRGA takes the nine states RD_I..XOR; DONE/LSBC report the result.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_I,
        ST_WT_I,
        ST_RD_J,
        ST_WT_J,
        ST_WR_I,
        ST_WR_J,
        ST_RD_F,
        ST_WT_F,
        ST_XOR,
        ST_DONE,
        ST_LSBC
    } prga_state_t;

    // A decrypted byte is plausible only if it is lower-case ASCII or a space.
    localparam logic [7:0] ASCII_LO = 8'h61;
    localparam logic [7:0] ASCII_HI = 8'h7A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    localparam int S_DEPTH = 256;

endpackage

// File: rtl/ascii_checker.sv
// Flags whether a byte is lower-case ASCII (a..z) or a space.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input byte.
module ascii_checker
    import rc4_pkg::*;
(
    input  logic [7:0] data_i,
    output logic       valid_o
);

    // Range test plus the single space code point.
    always_comb begin
        valid_o = ((data_i >= ASCII_LO) && (data_i <= ASCII_HI)) || (data_i == ASCII_SP);
    end

endmodule

// File: rtl/prga_decrypt_engine.sv
// RC4 PRGA: walks the shuffled S RAM, XORs keystream with the encrypted ROM, writes plaintext, grades each byte.
// Latency: start to finish pulse is 9*MSG_LEN+1 cycles (fewer with PRGA_EARLY_ABORT_EN when a bad byte stops the run).
// Backpressure: none; start is ignored while busy, restart aborts synchronously from any state.
module prga_decrypt_engine
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32,
    parameter int K_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           restart,
    output logic [7:0]     s_addr,
    output logic [7:0]     s_wdata,
    output logic           s_wren,
    input  logic [7:0]     s_rdata,
    output logic [K_W-1:0] enc_addr,
    input  logic [7:0]     enc_rdata,
    output logic [K_W-1:0] dec_addr,
    output logic [7:0]     dec_wdata,
    output logic           dec_wren,
    output logic           busy,
    output logic           finish,
    output logic           lsbc_done,
    output logic           key_wrong
);

    localparam int S_AW = $clog2(S_DEPTH);
    localparam logic [K_W-1:0] K_LAST = K_W'(MSG_LEN - 1);

`ifdef PRGA_EARLY_ABORT_EN
    localparam bit EARLY_ABORT = 1'b1;
`else
    localparam bit EARLY_ABORT = 1'b0;
`endif

    prga_state_t     state_q, state_d;
    logic [S_AW-1:0] i_q, i_d;
    logic [S_AW-1:0] j_q, j_d;
    logic [K_W-1:0]  k_q, k_d;
    logic [7:0]      si_q, si_d;
    logic [7:0]      sj_q, sj_d;
    logic [7:0]      f_q, f_d;
    logic [7:0]      e_q, e_d;
    logic            key_wrong_q, key_wrong_d;

    logic [7:0]      dec_byte;
    logic            byte_ok;

    // Plaintext byte is formed from the registered keystream and cipher bytes.
    assign dec_byte = f_q ^ e_q;

    ascii_checker u_chk (
        .data_i  (dec_byte),
        .valid_o (byte_ok)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            si_q        <= '0;
            sj_q        <= '0;
            f_q         <= '0;
            e_q         <= '0;
            key_wrong_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            f_q         <= f_d;
            e_q         <= e_d;
            key_wrong_q <= key_wrong_d;
        end
    end

    // Next-state, datapath updates and memory-port decode; restart overrides everything last.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        si_d        = si_q;
        sj_d        = sj_q;
        f_d         = f_q;
        e_d         = e_q;
        key_wrong_d = key_wrong_q;
        s_addr      = '0;
        s_wdata     = '0;
        s_wren      = 1'b0;
        enc_addr    = '0;
        dec_addr    = '0;
        dec_wdata   = '0;
        dec_wren    = 1'b0;
        finish      = 1'b0;
        lsbc_done   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // i is pre-incremented on entry to RD_I, so the first byte uses i=1.
                    state_d     = ST_RD_I;
                    i_d         = 8'd1;
                    j_d         = '0;
                    k_d         = '0;
                    key_wrong_d = 1'b0;
                end
            end
            ST_RD_I: begin
                s_addr  = i_q;
                state_d = ST_WT_I;
            end
            ST_WT_I: begin
                si_d    = s_rdata;
                state_d = ST_RD_J;
            end
            ST_RD_J: begin
                j_d     = j_q + si_q;
                s_addr  = j_q + si_q;
                state_d = ST_WT_J;
            end
            ST_WT_J: begin
                sj_d    = s_rdata;
                state_d = ST_WR_I;
            end
            ST_WR_I: begin
                s_addr  = i_q;
                s_wdata = sj_q;
                s_wren  = 1'b1;
                state_d = ST_WR_J;
            end
            ST_WR_J: begin
                s_addr  = j_q;
                s_wdata = si_q;
                s_wren  = 1'b1;
                state_d = ST_RD_F;
            end
            ST_RD_F: begin
                s_addr   = si_q + sj_q;
                enc_addr = k_q;
                state_d  = ST_WT_F;
            end
            ST_WT_F: begin
                f_d     = s_rdata;
                e_d     = enc_rdata;
                state_d = ST_XOR;
            end
            ST_XOR: begin
                dec_addr  = k_q;
                dec_wdata = dec_byte;
                dec_wren  = 1'b1;
                if (!byte_ok) begin
                    key_wrong_d = 1'b1;
                end
                if ((k_q == K_LAST) || (EARLY_ABORT && !byte_ok)) begin
                    state_d = ST_DONE;
                end else begin
                    k_d     = k_q + K_W'(1);
                    i_d     = i_q + 8'd1;
                    state_d = ST_RD_I;
                end
            end
            ST_DONE: begin
                finish  = 1'b1;
                state_d = ST_LSBC;
            end
            ST_LSBC: begin
                lsbc_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (restart) begin
            state_d     = ST_IDLE;
            i_d         = '0;
            j_d         = '0;
            k_d         = '0;
            key_wrong_d = 1'b0;
            s_wren      = 1'b0;
            dec_wren    = 1'b0;
            finish      = 1'b0;
            lsbc_done   = 1'b0;
        end
    end

    // Busy covers the byte-processing states only; it drops as the result is reported.
    always_comb begin
        busy = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_LSBC);
    end

    assign key_wrong = key_wrong_q;

endmodule

// File: tb/tb_prga_decrypt_engine.sv
// Directed bench for prga_decrypt_engine: a 3-byte instance and a 32-byte instance share one stimulus thread.
module tb_prga_decrypt_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic restart = 1'b0;
    logic sel = 1'b0;
    always #5 clk = ~clk;

    // Instance A: MSG_LEN=3
    logic [7:0] s_addr_a, s_wdata_a, s_rdata_a, enc_rdata_a, dec_wdata_a;
    logic [1:0] enc_addr_a, dec_addr_a;
    logic       s_wren_a, dec_wren_a, busy_a, finish_a, lsbc_a, kw_a;
    // Instance B: MSG_LEN=32
    logic [7:0] s_addr_b, s_wdata_b, s_rdata_b, enc_rdata_b, dec_wdata_b;
    logic [4:0] enc_addr_b, dec_addr_b;
    logic       s_wren_b, dec_wren_b, busy_b, finish_b, lsbc_b, kw_b;

    logic start_a, start_b, restart_a, restart_b;
    assign start_a   = start & ~sel;
    assign start_b   = start & sel;
    assign restart_a = restart & ~sel;
    assign restart_b = restart & sel;

    prga_decrypt_engine #(.MSG_LEN(3), .K_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .restart(restart_a),
        .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_wren(s_wren_a), .s_rdata(s_rdata_a),
        .enc_addr(enc_addr_a), .enc_rdata(enc_rdata_a),
        .dec_addr(dec_addr_a), .dec_wdata(dec_wdata_a), .dec_wren(dec_wren_a),
        .busy(busy_a), .finish(finish_a), .lsbc_done(lsbc_a), .key_wrong(kw_a)
    );

    prga_decrypt_engine #(.MSG_LEN(32), .K_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .restart(restart_b),
        .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_wren(s_wren_b), .s_rdata(s_rdata_b),
        .enc_addr(enc_addr_b), .enc_rdata(enc_rdata_b),
        .dec_addr(dec_addr_b), .dec_wdata(dec_wdata_b), .dec_wren(dec_wren_b),
        .busy(busy_b), .finish(finish_b), .lsbc_done(lsbc_b), .key_wrong(kw_b)
    );

    // Observation mux onto whichever instance is selected.
    logic [7:0] dec_addr_m, dec_wdata_m;
    logic       dec_wren_m, s_wren_m, busy_m, finish_m, lsbc_m, kw_m;
    assign dec_addr_m  = sel ? {3'b000, dec_addr_b} : {6'b000000, dec_addr_a};
    assign dec_wdata_m = sel ? dec_wdata_b : dec_wdata_a;
    assign dec_wren_m  = sel ? dec_wren_b  : dec_wren_a;
    assign s_wren_m    = sel ? s_wren_b    : s_wren_a;
    assign busy_m      = sel ? busy_b      : busy_a;
    assign finish_m    = sel ? finish_b    : finish_a;
    assign lsbc_m      = sel ? lsbc_b      : lsbc_a;
    assign kw_m        = sel ? kw_b        : kw_a;

    // Memory models: synchronous read, old data on read-during-write.
    logic [7:0] sa [256];
    logic [7:0] sb [256];
    logic [7:0] enca [4];
    logic [7:0] encb [32];
    always @(posedge clk) begin
        s_rdata_a   <= sa[s_addr_a];
        enc_rdata_a <= enca[enc_addr_a];
        s_rdata_b   <= sb[s_addr_b];
        enc_rdata_b <= encb[enc_addr_b];
        if (s_wren_a) sa[s_addr_a] = s_wdata_a;
        if (s_wren_b) sb[s_addr_b] = s_wdata_b;
    end

    // Reference data for the 32-byte run.
    logic [7:0] ksa_s [256];
    logic [7:0] ksm [32];
    logic [7:0] ptxt [32];
    logic [7:0] dec_cap [256];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic build_model(input logic [23:0] key);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] j, i, t;
        kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            j = j + s[n] + kb[n % 3];
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        for (int n = 0; n < 256; n++) ksa_s[n] = s[n];
        i = 8'd0; j = 8'd0;
        for (int n = 0; n < 32; n++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[i] + s[j];
            ksm[n]  = s[t];
            ptxt[n] = 8'h61 + 8'(n % 26);
        end
    endtask

    task automatic load_a(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        for (int n = 0; n < 256; n++) sa[n] = 8'(n);
        enca[0] = e0; enca[1] = e1; enca[2] = e2; enca[3] = 8'h00;
    endtask

    task automatic load_b(input bit corrupt0);
        for (int n = 0; n < 256; n++) sb[n] = ksa_s[n];
        for (int n = 0; n < 32; n++) encb[n] = ptxt[n] ^ ksm[n];
        if (corrupt0) encb[0] = ksm[0];
    endtask

    // Start a run on the selected instance and follow it to lsbc_done (bounded).
    task automatic run_msg(input int extra_start_at, output int fin_at, output int lsbc_at,
                           output int nwr, output logic kw_first, output logic kw_lsbc);
        int cyc;
        fin_at = -1; lsbc_at = -1; nwr = 0; kw_first = 1'bx; kw_lsbc = 1'bx;
        for (int n = 0; n < 256; n++) dec_cap[n] = 8'hxx;
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        while (cyc < 2000 && lsbc_at < 0) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1) kw_first = kw_m;
            if (dec_wren_m) begin
                dec_cap[dec_addr_m] = dec_wdata_m;
                nwr++;
            end
            if (finish_m && fin_at < 0) fin_at = cyc;
            if (lsbc_m) begin
                lsbc_at = cyc;
                kw_lsbc = kw_m;
            end
            start = (cyc == extra_start_at);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy_a, finish_a, lsbc_a, kw_a, s_wren_a, dec_wren_a} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl_a: got %b want 000000", {busy_a, finish_a, lsbc_a, kw_a, s_wren_a, dec_wren_a});
        end
        n_checks++;
        if ({busy_b, finish_b, lsbc_b, kw_b, s_wren_b, dec_wren_b} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl_b: got %b want 000000", {busy_b, finish_b, lsbc_b, kw_b, s_wren_b, dec_wren_b});
        end
        n_checks++;
        if ({s_addr_a, s_wdata_a, dec_wdata_a, enc_addr_a, dec_addr_a} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_bus_a: got %h want 0", {s_addr_a, s_wdata_a, dec_wdata_a, enc_addr_a, dec_addr_a});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int fin, lsb, nwr, bad;
        logic kf, kl;
        sel = 1'b0;
        load_a(8'h63, 8'h64, 8'h66);
        run_msg(-1, fin, lsb, nwr, kf, kl);
        n_checks++;
        if (fin != 28) begin n_fail++; $display("FAIL basic_latency: got %0d want 28", fin); end
        n_checks++;
        if (lsb != 29) begin n_fail++; $display("FAIL basic_lsbc: got %0d want 29", lsb); end
        n_checks++;
        if (nwr != 3) begin n_fail++; $display("FAIL basic_nwr: got %0d want 3", nwr); end
        for (int n = 0; n < 3; n++) begin
            n_checks++;
            if (dec_cap[n] !== 8'h61) begin n_fail++; $display("FAIL basic_dec%0d: got %h want 61", n, dec_cap[n]); end
        end
        n_checks++;
        if (kl !== 1'b0) begin n_fail++; $display("FAIL basic_kw: got %b want 0", kl); end
        n_checks++;
        if ({sa[2], sa[3], sa[5]} !== 24'h030502) begin
            n_fail++; $display("FAIL basic_swaps: got %h want 030502", {sa[2], sa[3], sa[5]});
        end
        bad = 0;
        for (int n = 0; n < 256; n++)
            if (n != 2 && n != 3 && n != 5 && sa[n] !== 8'(n)) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL basic_s_identity: got %0d changed want 0", bad); end
    endtask

    task automatic test_key_wrong();
        int fin, lsb, nwr;
        logic kf, kl;
        sel = 1'b0;
        load_a(8'h63, 8'h64, 8'h00);
        run_msg(-1, fin, lsb, nwr, kf, kl);
        n_checks++;
        if (dec_cap[2] !== 8'h07) begin n_fail++; $display("FAIL kw_dec2: got %h want 07", dec_cap[2]); end
        n_checks++;
        if (kl !== 1'b1) begin n_fail++; $display("FAIL kw_at_lsbc: got %b want 1", kl); end
        repeat (6) @(negedge clk);
        n_checks++;
        if (kw_a !== 1'b1) begin n_fail++; $display("FAIL kw_hold: got %b want 1", kw_a); end
    endtask

    task automatic test_start_while_busy();
        int fin, lsb, nwr;
        logic kf, kl;
        sel = 1'b0;
        load_a(8'h63, 8'h64, 8'h66);
        run_msg(10, fin, lsb, nwr, kf, kl);
        n_checks++;
        if (kf !== 1'b0) begin n_fail++; $display("FAIL swb_kw_cleared: got %b want 0", kf); end
        n_checks++;
        if (fin != 28 || nwr != 3) begin n_fail++; $display("FAIL swb_latency: got %0d/%0d want 28/3", fin, nwr); end
        n_checks++;
        if ({dec_cap[0], dec_cap[1], dec_cap[2]} !== 24'h616161 || kl !== 1'b0) begin
            n_fail++; $display("FAIL swb_dec: got %h kw %b want 616161 kw 0", {dec_cap[0], dec_cap[1], dec_cap[2]}, kl);
        end
        repeat (12) @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL swb_idle_after: got %b want 0", busy_a); end
    endtask

    task automatic test_full_length();
        int fin, lsb, nwr, bad;
        logic kf, kl;
        sel = 1'b1;
        load_b(1'b0);
        run_msg(-1, fin, lsb, nwr, kf, kl);
        n_checks++;
        if (fin != 289) begin n_fail++; $display("FAIL full_latency: got %0d want 289", fin); end
        n_checks++;
        if (nwr != 32) begin n_fail++; $display("FAIL full_nwr: got %0d want 32", nwr); end
        bad = 0;
        for (int n = 0; n < 32; n++) if (dec_cap[n] !== ptxt[n]) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL full_dec: got %0d wrong bytes want 0", bad); end
        n_checks++;
        if (kl !== 1'b0) begin n_fail++; $display("FAIL full_kw: got %b want 0", kl); end
    endtask

    task automatic test_restart();
        int nwr, cyc, stray, fin, lsb, bad;
        logic kf, kl;
        sel = 1'b1;
        load_b(1'b1);
        nwr = 0; cyc = 0;
        @(negedge clk);
        start = 1'b1;
        while (nwr < 5 && cyc < 200) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            start = 1'b0;
            if (dec_wren_m) nwr++;
        end
        n_checks++;
        if (nwr != 5) begin n_fail++; $display("FAIL restart_reach: got %0d writes want 5", nwr); end
        repeat (5) @(negedge clk);
        n_checks++;
        if (s_wren_m !== 1'b1 || kw_m !== 1'b1) begin
            n_fail++; $display("FAIL restart_pre: got wren %b kw %b want 1 1", s_wren_m, kw_m);
        end
        restart = 1'b1;
        #1;
        n_checks++;
        if (s_wren_m !== 1'b0) begin n_fail++; $display("FAIL restart_gate: got %b want 0", s_wren_m); end
        @(negedge clk);
        restart = 1'b0;
        n_checks++;
        if (busy_m !== 1'b0 || kw_m !== 1'b0) begin
            n_fail++; $display("FAIL restart_clear: got busy %b kw %b want 0 0", busy_m, kw_m);
        end
        stray = 0;
        repeat (400) begin
            @(negedge clk);
            if (finish_m || lsbc_m || dec_wren_m || s_wren_m || busy_m) stray++;
        end
        n_checks++;
        if (stray != 0) begin n_fail++; $display("FAIL restart_quiet: got %0d active cycles want 0", stray); end
        load_b(1'b0);
        run_msg(-1, fin, lsb, nwr, kf, kl);
        bad = 0;
        for (int n = 0; n < 32; n++) if (dec_cap[n] !== ptxt[n]) bad++;
        n_checks++;
        if (bad != 0 || fin != 289 || kl !== 1'b0) begin
            n_fail++; $display("FAIL restart_rerun: got %0d bad, fin %0d, kw %b want 0, 289, 0", bad, fin, kl);
        end
    endtask

    task automatic test_early_abort();
        int fin, lsb, nwr;
        logic kf, kl;
        sel = 1'b0;
        load_a(8'h00, 8'h64, 8'h66);
        run_msg(-1, fin, lsb, nwr, kf, kl);
        n_checks++;
        if (dec_cap[0] !== 8'h02 || kl !== 1'b1) begin
            n_fail++; $display("FAIL abort_byte0: got %h kw %b want 02 kw 1", dec_cap[0], kl);
        end
`ifdef PRGA_EARLY_ABORT_EN
        n_checks++;
        if (fin != 10 || nwr != 1) begin n_fail++; $display("FAIL abort_early: got %0d/%0d want 10/1", fin, nwr); end
`else
        n_checks++;
        if (fin != 28 || nwr != 3) begin n_fail++; $display("FAIL abort_full: got %0d/%0d want 28/3", fin, nwr); end
        n_checks++;
        if ({dec_cap[1], dec_cap[2]} !== 16'h6161) begin
            n_fail++; $display("FAIL abort_rest: got %h want 6161", {dec_cap[1], dec_cap[2]});
        end
`endif
    endtask

    initial begin
        build_model(24'h000001);
        for (int n = 0; n < 4; n++) enca[n] = 8'h00;
        for (int n = 0; n < 32; n++) encb[n] = 8'h00;
        for (int n = 0; n < 256; n++) begin sa[n] = 8'(n); sb[n] = 8'(n); end
        test_reset();
        test_basic();
        test_key_wrong();
        test_start_while_busy();
        test_full_length();
        test_restart();
        test_early_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
